// File: rtl/cache_rw_lookup.sv
// cache_rw_lookup: N-way set-associative lookup/control engine for the data cache.
// Keeps the tag, valid and per-byte readable (re) state in flops. Checks for hits,
// picks a victim way round-robin, issues refill, IO and control commands, and
// replays an access after a refill. The data RAM lives outside this block and is
// addressed through hitWay and m0_way.
//
// Ports
//   clk, rest          : clock, synchronous active-high reset
//   s0_*               : CPU slave access (address, byteEnable, read, write,
//                        waitRequest, done) with hitWay valid during s0_done
//   isIOAddrBlock      : current access targets IO space (uncacheable)
//   isEnableCache      : cache enable
//   isRequest          : level request for invalidate-all followed by a control command
//   m0_cmd/_valid/_ready, m0_address, m0_way : command to the refill/IO unit
//   fill_done          : refill/IO/control completion pulse
// Optional: define CACHE_RW_STAT_EN to add hitCount/missCount outputs.

module cache_rw_way_cmp #(
  parameter int TW = 21
) (
  input  logic [TW-1:0] lineTag,
  input  logic          lineValid,
  input  logic [TW-1:0] reqTag,
  output logic          match
);
  assign match = lineValid && (lineTag == reqTag);
endmodule

module cache_rw_lookup #(
  parameter  int SIZE       = 8192,
  parameter  int WAYS       = 4,
  parameter  int LINE_WORDS = 16,
  localparam int WW         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk,
  input  logic          rest,
  input  logic [31:0]   s0_address,
  input  logic [3:0]    s0_byteEnable,
  input  logic          s0_read,
  input  logic          s0_write,
  output logic          s0_waitRequest,
  output logic          s0_done,
  output logic [WW-1:0] hitWay,
  input  logic          isIOAddrBlock,
  input  logic          isEnableCache,
  input  logic          isRequest,
  output logic [3:0]    m0_cmd,
  output logic          m0_cmd_valid,
  input  logic          m0_cmd_ready,
  output logic [31:0]   m0_address,
  output logic [WW-1:0] m0_way,
  input  logic          fill_done
`ifdef CACHE_RW_STAT_EN
  ,
  output logic [31:0]   hitCount,
  output logic [31:0]   missCount
`endif
);
  localparam int SETS = SIZE / (4 * LINE_WORDS * WAYS);
  localparam int SW   = $clog2(SETS);
  localparam int OW   = $clog2(LINE_WORDS) + 2;
  localparam int TW   = 32 - SW - OW;
  localparam int SIW  = (SW > 0) ? SW : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, CMD, WAIT, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic        io;
    logic        en;
  } req_t;

  state_t state, stateNext;
  req_t   req;

  logic [WAYS-1:0][TW-1:0] tagMem   [SETS];
  logic [WAYS-1:0]         validMem [SETS];
  logic [WAYS-1:0][3:0]    reMem    [SETS];

  logic [SIW-1:0] setIdx, flushCnt;
  logic [TW-1:0]  reqTag;
  logic [WW-1:0]  victim, hitIdx, freeIdx;
  logic           victimFree, hitAny, freeAny, good;
  logic [WAYS-1:0] match;

  if (SW > 0) begin : gSet
    assign setIdx = req.addr[SW+OW-1:OW];
  end else begin : gNoSet
    assign setIdx = '0;
  end
  assign reqTag = req.addr[31:SW+OW];

  cache_rw_way_cmp #(.TW(TW)) uCmp [WAYS-1:0] (
    .lineTag  (tagMem[setIdx]),
    .lineValid(validMem[setIdx]),
    .reqTag   ({WAYS{reqTag}}),
    .match    (match)
  );

  // Tags are unique within a set, so at most one match bit is ever set.
  // The second loop runs downward so that the lowest invalid way is the one kept.
  always_comb begin
    hitAny  = 1'b0;
    hitIdx  = '0;
    freeAny = 1'b0;
    freeIdx = '0;
    for (int w = 0; w < WAYS; w++)
      if (match[w]) begin
        hitAny = 1'b1;
        hitIdx = WW'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!validMem[setIdx][w]) begin
        freeAny = 1'b1;
        freeIdx = WW'(w);
      end
  end

  assign good = hitAny && !req.io && req.en &&
                (req.wr || ((reMem[setIdx][hitIdx] & req.be) == req.be));

  assign s0_waitRequest = (state != IDLE);

  always_ff @(posedge clk)
    if (rest) state <= IDLE;
    else      state <= stateNext;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (s0_read || s0_write) stateNext = LOOKUP;
               else if (isRequest)      stateNext = FLUSH;
      LOOKUP:  stateNext = good ? IDLE : CMD;
      CMD:     if (m0_cmd_ready) stateNext = WAIT;
      WAIT:    if (fill_done) stateNext = (m0_cmd == 4'd1) ? LOOKUP : IDLE;
      FLUSH:   if (flushCnt == SIW'(SETS - 1)) stateNext = CMD;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      req          <= '0;
      victim       <= '0;
      victimFree   <= 1'b0;
      flushCnt     <= '0;
      s0_done      <= 1'b0;
      hitWay       <= '0;
      m0_cmd       <= '0;
      m0_cmd_valid <= 1'b0;
      m0_address   <= '0;
      m0_way       <= '0;
      for (int s = 0; s < SETS; s++) begin
        validMem[s] <= '0;
        reMem[s]    <= '0;
      end
`ifdef CACHE_RW_STAT_EN
      hitCount  <= '0;
      missCount <= '0;
`endif
    end else begin
      s0_done <= 1'b0;
`ifdef CACHE_RW_STAT_EN
      if (s0_done) hitCount <= hitCount + 32'd1;
`endif
      unique case (state)
        IDLE: begin
          flushCnt <= '0;
          if (s0_read || s0_write) begin
            req.addr <= s0_address;
            req.be   <= s0_byteEnable;
            req.wr   <= s0_write;  // read+write together counts as a write
            req.io   <= isIOAddrBlock;
            req.en   <= isEnableCache;
          end
        end
        LOOKUP: begin
          if (good) begin
            s0_done <= 1'b1;
            hitWay  <= hitIdx;
            if (req.wr) reMem[setIdx][hitIdx] <= reMem[setIdx][hitIdx] | req.be;
          end else begin
            m0_cmd       <= (req.io || !req.en) ? 4'd2 : 4'd1;
            m0_way       <= freeAny ? freeIdx : victim;
            victimFree   <= freeAny;
            m0_address   <= req.addr;
            m0_cmd_valid <= 1'b1;
`ifdef CACHE_RW_STAT_EN
            missCount <= missCount + 32'd1;
`endif
          end
        end
        CMD: if (m0_cmd_ready) m0_cmd_valid <= 1'b0;
        WAIT: begin
          if (fill_done && m0_cmd == 4'd1) begin
            validMem[setIdx][m0_way] <= 1'b1;
            reMem[setIdx][m0_way]    <= 4'hF;
            // Filling an empty way does not consume a round-robin slot.
            if (!victimFree)
              victim <= (victim == WW'(WAYS - 1)) ? '0 : victim + 1'b1;
          end
        end
        FLUSH: begin
          validMem[flushCnt] <= '0;
          reMem[flushCnt]    <= '0;
          flushCnt           <= flushCnt + 1'b1;
          if (flushCnt == SIW'(SETS - 1)) begin
            m0_cmd       <= 4'd3;
            m0_cmd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset because a tag is only trusted while its valid bit is set.
  always_ff @(posedge clk)
    if (!rest && state == WAIT && fill_done && m0_cmd == 4'd1)
      tagMem[setIdx][m0_way] <= reqTag;

endmodule
